wb_stage: RTL and testbench

- Write-back stage of the 5-stage MIPS-style pipeline.
- Latches the MEM/WB pipeline register and selects the result: load data or ALU result.
- Drives the register file's write port (write, writeaddress, writedata), which the decode stage reads.
- Guarantees exactly one register-file write per retired instruction under stall and flush, and keeps a retired-instruction counter.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_retire_counter.sv | 34 +++
 rtl/wb_stage.sv | 113 +++++++++++
 tb/tb_wb_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back stage.
// State encoding is exported so that the top can expose it on a debug port.
package wb_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_CNT_WIDTH      = 32;

    // Register index that is hard-wired to zero in the register file.
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        HELD   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_retire_counter.sv
// Retired-instruction counter: async active-low clear, +1 per enabled cycle,
// wraps modulo 2^CNT_WIDTH.
module wb_retire_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_en,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_d;
    logic [CNT_WIDTH-1:0] count_q;

    // Next count: increment when enabled, natural wrap on overflow.
    always_comb begin
        count_d = count_q;
        if (inc_en) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, result select and register-file write port.
// An entry writes only in its first (ACTIVE) cycle, so a stalled entry never
// writes twice. Optional forwarding outputs are enabled by defining WB_FWD_EN;
// without it the forwarding ports are tied to 0.
//
// Handshake: there is no valid/ready pair here; mem_valid qualifies the MEM
// inputs on any edge where stall=0 and flush=0, and stall/flush act as the
// back-pressure and kill controls for the held entry.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_valid,
    input  logic                      mem_wb_en,
    input  logic                      mem_r_en,
    input  logic [DATA_WIDTH-1:0]     mem_alu_result,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic [REG_ADDR_WIDTH-1:0] mem_dest,
    input  logic                      stall,
    input  logic                      flush,
    output logic                      write,
    output logic [REG_ADDR_WIDTH-1:0] writeaddress,
    output logic [DATA_WIDTH-1:0]     writedata,
    output logic                      wb_valid,
    output logic [CNT_WIDTH-1:0]      retired_count,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_dest,
    output logic [DATA_WIDTH-1:0]     fwd_data,
    output wb_state_e                 dbg_state
);

    wb_state_e                 state_d, state_q;
    logic                      wb_en_d, wb_en_q;
    logic                      r_en_d, r_en_q;
    logic [DATA_WIDTH-1:0]     alu_d, alu_q;
    logic [DATA_WIDTH-1:0]     rdata_d, rdata_q;
    logic [REG_ADDR_WIDTH-1:0] dest_d, dest_q;
    logic                      dest_nz;

    // Next-state and register load: flush beats stall, stall holds the data.
    always_comb begin
        state_d = state_q;
        wb_en_d = wb_en_q;
        r_en_d  = r_en_q;
        alu_d   = alu_q;
        rdata_d = rdata_q;
        dest_d  = dest_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (!stall) begin
            state_d = mem_valid ? ACTIVE : EMPTY;
            wb_en_d = mem_wb_en;
            r_en_d  = mem_r_en;
            alu_d   = mem_alu_result;
            rdata_d = mem_rdata;
            dest_d  = mem_dest;
        end else if (state_q == ACTIVE) begin
            state_d = HELD;
        end
    end

    // MEM/WB pipeline register and stage state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            wb_en_q <= 1'b0;
            r_en_q  <= 1'b0;
            alu_q   <= '0;
            rdata_q <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            wb_en_q <= wb_en_d;
            r_en_q  <= r_en_d;
            alu_q   <= alu_d;
            rdata_q <= rdata_d;
            dest_q  <= dest_d;
        end
    end

    assign dest_nz      = (dest_q != REG_ADDR_WIDTH'(REG_ZERO));
    assign write        = (state_q == ACTIVE) & wb_en_q & dest_nz;
    assign writeaddress = dest_q;
    assign writedata    = r_en_q ? rdata_q : alu_q;
    assign wb_valid     = (state_q != EMPTY);
    assign dbg_state    = state_q;

    // The ACTIVE cycle is the retire cycle, whether or not it writes.
    wb_retire_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_retire_counter (
        .clk   (clk),
        .rst   (rst),
        .inc_en(state_q == ACTIVE),
        .count (retired_count)
    );

`ifdef WB_FWD_EN
    assign fwd_valid = wb_valid & wb_en_q & dest_nz;
    assign fwd_dest  = dest_q;
    assign fwd_data  = writedata;
`else
    assign fwd_valid = 1'b0;
    assign fwd_dest  = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a vector table for single-cycle behaviour plus
// hand-written stall, flush, forwarding, reset-mid-stall and wrap sequences.
module tb_wb_stage;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_wb_en = 1'b0;
    logic        mem_r_en = 1'b0;
    logic [31:0] mem_alu_result = '0;
    logic [31:0] mem_rdata = '0;
    logic [4:0]  mem_dest = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic        write, wb_valid, fwd_valid;
    logic [4:0]  writeaddress, fwd_dest;
    logic [31:0] writedata, fwd_data, retired_count;
    wb_state_e   dbg_state;

    // Narrow-counter instance sharing the same stimulus, used to reach the wrap.
    logic        s_write, s_wb_valid, s_fwd_valid;
    logic [4:0]  s_writeaddress, s_fwd_dest;
    logic [31:0] s_writedata, s_fwd_data;
    logic [2:0]  s_count;
    wb_state_e   s_state;

    int n_tests = 0;
    int n_fail  = 0;

    wb_stage dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wb_en(mem_wb_en),
        .mem_r_en(mem_r_en), .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
        .mem_dest(mem_dest), .stall(stall), .flush(flush), .write(write),
        .writeaddress(writeaddress), .writedata(writedata), .wb_valid(wb_valid),
        .retired_count(retired_count), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
        .fwd_data(fwd_data), .dbg_state(dbg_state)
    );

    wb_stage #(.CNT_WIDTH(3)) dut_small (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wb_en(mem_wb_en),
        .mem_r_en(mem_r_en), .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
        .mem_dest(mem_dest), .stall(stall), .flush(flush), .write(s_write),
        .writeaddress(s_writeaddress), .writedata(s_writedata), .wb_valid(s_wb_valid),
        .retired_count(s_count), .fwd_valid(s_fwd_valid), .fwd_dest(s_fwd_dest),
        .fwd_data(s_fwd_data), .dbg_state(s_state)
    );

    // Clock.
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        we;
        logic        re;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [4:0]  dest;
        logic        st;
        logic        fl;
        logic        e_write;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic re,
                         input logic [31:0] alu, input logic [31:0] rd,
                         input logic [4:0] dest, input logic st, input logic fl);
        mem_valid      = v;
        mem_wb_en      = we;
        mem_r_en       = re;
        mem_alu_result = alu;
        mem_rdata      = rd;
        mem_dest       = dest;
        stall          = st;
        flush          = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          v     we    re    alu           rdata         dest   st    fl    write addr   data          valid cnt
        tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_1234, 32'h0,       5'd5,  1'b0, 1'b0, 1'b1, 5'd5,  32'h0000_1234, 1'b1, 32'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h10,       32'hDEAD_BEEF, 5'd3, 1'b0, 1'b0, 1'b1, 5'd3,  32'hDEAD_BEEF, 1'b1, 32'd1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h10,       32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  32'hDEAD_BEEF, 1'b1, 32'd2};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'd3};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 32'hAA,       32'h0,        5'd4,  1'b0, 1'b0, 1'b0, 5'd4,  32'hAA,       1'b1, 32'd3};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'd4};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h77,       32'h0,        5'd31, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'd4};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 32'hCAFE,     32'h0,        5'd2,  1'b0, 1'b0, 1'b1, 5'd2,  32'hCAFE,     1'b1, 32'd4};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 32'hBEEF,     32'h0,        5'd6,  1'b0, 1'b1, 1'b0, 5'd2,  32'hCAFE,     1'b0, 32'd5};

        // Reset held for two cycles, then idle.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_write", 32'(write), 32'd0);
        chk("reset_valid", 32'(wb_valid), 32'd0);
        chk("reset_count", retired_count, 32'd0);
        chk("reset_addr", 32'(writeaddress), 32'd0);
        chk("reset_data", writedata, 32'd0);
        chk("reset_state", 32'(dbg_state), 32'(EMPTY));
        chk("reset_fwd_valid", 32'(fwd_valid), 32'd0);
        rst = 1'b1;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].we, tbl[i].re, tbl[i].alu, tbl[i].rd,
                  tbl[i].dest, tbl[i].st, tbl[i].fl);
            step();
            chk($sformatf("vec%0d_write", i), 32'(write), 32'(tbl[i].e_write));
            chk($sformatf("vec%0d_addr", i), 32'(writeaddress), 32'(tbl[i].e_addr));
            chk($sformatf("vec%0d_data", i), writedata, tbl[i].e_data);
            chk($sformatf("vec%0d_valid", i), 32'(wb_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_count", i), retired_count, tbl[i].e_cnt);
        end

        // Stall mid-entry: one write, then three held cycles with changing inputs.
        drive(1'b1, 1'b1, 1'b0, 32'h70, 32'h0, 5'd7, 1'b0, 1'b0);
        step();
        chk("stall_first_write", 32'(write), 32'd1);
        chk("stall_first_state", 32'(dbg_state), 32'(ACTIVE));
        chk("stall_first_count", retired_count, 32'd5);
        drive(1'b1, 1'b1, 1'b0, 32'hFFFF, 32'h0, 5'd12, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall%0d_write", k), 32'(write), 32'd0);
            chk($sformatf("stall%0d_state", k), 32'(dbg_state), 32'(HELD));
            chk($sformatf("stall%0d_valid", k), 32'(wb_valid), 32'd1);
            chk($sformatf("stall%0d_addr", k), 32'(writeaddress), 32'd7);
            chk($sformatf("stall%0d_data", k), writedata, 32'h70);
            chk($sformatf("stall%0d_count", k), retired_count, 32'd6);
        end

        // Flush and stall together while HELD: flush wins.
        drive(1'b1, 1'b1, 1'b0, 32'hFFFF, 32'h0, 5'd12, 1'b1, 1'b1);
        step();
        chk("flush_held_state", 32'(dbg_state), 32'(EMPTY));
        chk("flush_held_write", 32'(write), 32'd0);
        chk("flush_held_valid", 32'(wb_valid), 32'd0);
        chk("flush_held_count", retired_count, 32'd6);

        // Forwarding source held through HELD.
        drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 5'd9, 1'b0, 1'b0);
        step();
        chk("fwd_active_count", retired_count, 32'd6);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
        step();
        chk("fwd_held_state", 32'(dbg_state), 32'(HELD));
        chk("fwd_held_count", retired_count, 32'd7);
`ifdef WB_FWD_EN
        chk("fwd_valid", 32'(fwd_valid), 32'd1);
        chk("fwd_dest", 32'(fwd_dest), 32'd9);
        chk("fwd_data", fwd_data, 32'h55);
`else
        chk("fwd_valid_tied", 32'(fwd_valid), 32'd0);
        chk("fwd_dest_tied", 32'(fwd_dest), 32'd0);
        chk("fwd_data_tied", fwd_data, 32'd0);
`endif
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        chk("fwd_after_valid", 32'(fwd_valid), 32'd0);
        chk("fwd_after_state", 32'(dbg_state), 32'(EMPTY));

        // Reset asserted mid-stall discards the held entry.
        drive(1'b1, 1'b1, 1'b0, 32'h88, 32'h0, 5'd8, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h88, 32'h0, 5'd8, 1'b1, 1'b0);
        step();
        chk("pre_reset_state", 32'(dbg_state), 32'(HELD));
        chk("pre_reset_count", retired_count, 32'd8);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_state", 32'(dbg_state), 32'(EMPTY));
        chk("midrst_write", 32'(write), 32'd0);
        chk("midrst_valid", 32'(wb_valid), 32'd0);
        chk("midrst_count", retired_count, 32'd0);
        chk("midrst_addr", 32'(writeaddress), 32'd0);
        chk("midrst_small_count", 32'(s_count), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk("postrst_write", 32'(write), 32'd0);
        chk("postrst_count", retired_count, 32'd0);

        // Back-to-back retires; the 3-bit counter reaches all-ones then wraps.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'(k * 17 + 1), 32'h0, 5'(k + 1), 1'b0, 1'b0);
            step();
            chk($sformatf("b2b%0d_write", k), 32'(write), 32'd1);
            chk($sformatf("b2b%0d_state", k), 32'(dbg_state), 32'(ACTIVE));
            chk($sformatf("b2b%0d_addr", k), 32'(writeaddress), 32'(k + 1));
            chk($sformatf("b2b%0d_data", k), writedata, 32'(k * 17 + 1));
            chk($sformatf("b2b%0d_count", k), retired_count, 32'(k));
            chk($sformatf("b2b%0d_small", k), 32'(s_count), 32'(k % 8));
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        chk("wrap_small_count", 32'(s_count), 32'd0);
        chk("wrap_big_count", retired_count, 32'd8);
        chk("wrap_write", 32'(write), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
